dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Two-requester arbiter in front of the single-port data memory.
//   Port A is the MEM stage (priority); port B is the debug/DMA master.
//   Forwards one command per cycle and tracks the memory's 1-cycle registered
//   read latency, returning read data to the issuing port.
//   Aging counter guarantees port B forward progress under continuous A traffic.
// PARAMETERS
//   ADDR_W        32  address width (byte address; memory uses addr[ADDR_W-1:2])
//   DATA_W        32  data width
//   STARVE_LIMIT  8   consecutive denied B cycles before B is forced; legal 1..2**AGE_W-1
//   AGE_W         4   aging counter width
// PORTS
//   clk          in   1       clock, all state on posedge
//   reset_n      in   1       asynchronous active-low reset
//   a_req        in   1       port A request; held stable until a_gnt
//   a_we         in   1       1=write, 0=read
//   a_addr       in   ADDR_W  byte address
//   a_wdata      in   DATA_W  write data (byte/half data in low bits)
//   a_be         in   4       byte enable / access size
//   a_gnt        out  1       command accepted this cycle (combinational)
//   a_rvalid     out  1       read data valid for A
//   a_rdata      out  DATA_W  read data for A
//   a_err        out  1       see CONFIGURATION
//   b_*          -    -       identical set for port B (b_req..b_err)
//   mem_addr     out  ADDR_W  to memory addr
//   mem_wdata    out  DATA_W  to memory data_in
//   mem_read_en  out  1       to memory read_en
//   mem_write_en out  1       to memory write_en
//   mem_be       out  4       to memory byte_enable
//   mem_rdata    in   DATA_W  from memory data_out (valid cycle after read_en)
// BEHAVIOUR
//   - Reset: a/b_gnt, a/b_rvalid, a/b_err, mem_read_en, mem_write_en = 0;
//     rdata outputs 0; age = 0; FSM = NORMAL. Reset mid-read drops the read.
//   - FSM NORMAL: A granted whenever a_req; B granted only if !a_req.
//     Each cycle b_req && !b_gnt: age++ (saturating). At age==STARVE_LIMIT -> FORCE_B.
//   - FSM FORCE_B: B granted if b_req, even with a_req (A stalls, a_gnt=0);
//     on b_gnt age=0 -> NORMAL. If b_req drops, age=0 -> NORMAL.
//   - Any b_gnt clears age. Grants are one-hot; one mem command per cycle.
//   - Mem signals combinationally muxed from granted port; idle -> en=0,
//     addr/wdata/be=0.
//   - Read latency 1: read granted at cycle N -> x_rvalid=1 at N+1, x_rdata =
//     mem_rdata; owner registered at N. Back-to-back reads fully pipelined,
//     either port, no bubble.
//   - x_rdata holds its last value when x_rvalid=0.
//   - Write: done at grant edge; no response. Read same addr next cycle sees it.
// CONFIGURATION
//   DMEM_ALIGN_CHECK_EN defined: request whose be is not in {0001,0010,0100,
//     1000,0011,1100,1111} or whose addr[1:0] != lowest set be bit index is
//     granted but not forwarded (mem en=0); x_err pulses 1 cycle after grant,
//     with x_rvalid=0.
//   Undefined: all requests forwarded unchanged; a_err=b_err=0 constant.
// STRUCTURE
//   - Shared constants in core/constants.v: ARB_NORMAL/ARB_FORCE_B state
//     encodings, legal byte-enable codes.
//   - One sub-module: dmem_age_counter (saturating count, clear, limit compare).
//   - Rest (grant logic, mux, read-owner pipe, err) in dmem_arbiter.
// TESTING
//   1 Reset: reset_n=0 mid-read of A -> no a_rvalid after release; all outs 0.
//   2 A only: write 0xDEADBEEF @0x10 be=1111, then read @0x10 -> a_rvalid 1
//     cycle after grant, a_rdata=0xDEADBEEF.
//   3 Conflict: a_req=b_req=1 same cycle -> a_gnt=1, b_gnt=0; A drops -> b_gnt next.
//   4 Starvation: a_req held 20 cycles, b_req held, STARVE_LIMIT=8 -> b_gnt on
//     9th cycle, a_gnt=0 that cycle, A resumes the following cycle.
//   5 Pipelined reads: A@0x0, B@0x4, A@0x8 consecutive -> rvalid on owner
//     ports in order, data matches, no bubble cycles.
//   6 DMEM_ALIGN_CHECK_EN: A read addr=0x3 be=0011 -> mem_read_en=0, a_err
//     pulse next cycle; LB addr=0x2 be=0100 -> normal.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Holds the arbitration state encoding, the legal byte-enable codes and
// the alignment rule used when DMEM_ALIGN_CHECK_EN is defined.
package dmem_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_NORMAL  = 1'b0,
        ARB_FORCE_B = 1'b1
    } arb_state_t;

    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_BYTE1 = 4'b0010;
    localparam logic [3:0] BE_BYTE2 = 4'b0100;
    localparam logic [3:0] BE_BYTE3 = 4'b1000;
    localparam logic [3:0] BE_HALF0 = 4'b0011;
    localparam logic [3:0] BE_HALF1 = 4'b1100;
    localparam logic [3:0] BE_WORD  = 4'b1111;

    // Only naturally sized byte, halfword and word lanes are accepted.
    function automatic logic be_legal(input logic [3:0] be);
        return (be == BE_BYTE0) || (be == BE_BYTE1) || (be == BE_BYTE2) ||
               (be == BE_BYTE3) || (be == BE_HALF0) || (be == BE_HALF1) ||
               (be == BE_WORD);
    endfunction

    // Index of the lowest enabled byte lane (0 when no lane is enabled).
    function automatic logic [1:0] be_low_idx(input logic [3:0] be);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (be[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // The byte address must point at the first enabled lane.
    function automatic logic access_aligned(input logic [1:0] addr_lo, input logic [3:0] be);
        return be_legal(be) && (addr_lo == be_low_idx(be));
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus interfaces for the data-memory arbiter: one requester port type
// (used for both the MEM stage and the debug/DMA master) and the
// single-port memory command/return bus.
interface dmem_req_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        be;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata, err);
    modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata, err);
endinterface

interface dmem_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              read_en;
    logic              write_en;
    logic [3:0]        be;
    logic [DATA_W-1:0] rdata;

    modport master (output addr, wdata, read_en, write_en, be, input rdata);
    modport slave  (input addr, wdata, read_en, write_en, be, output rdata);
endinterface

// File: rtl/dmem_arbiter_age_counter.sv
// Saturating aging counter for the low-priority port.
// reach flags that the count is about to land on LIMIT this cycle, so the
// arbiter can switch to forcing the low-priority port on the very next cycle.
module dmem_age_counter #(
    parameter int AGE_W = 4,
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic reach
);
    localparam logic [AGE_W-1:0] LIMIT_V = AGE_W'(LIMIT);

    logic [AGE_W-1:0] count_reg;
    logic [AGE_W-1:0] count_next;

    // Clear wins over increment; increment stops at all-ones.
    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && (count_reg != '1)) begin
            count_next = count_reg + AGE_W'(1);
        end
        reach = (count_next == LIMIT_V);
    end

    // Age register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the single-port data memory.
// Port a (MEM stage) has priority; port b (debug/DMA) is guaranteed
// progress by an aging counter that forces one b grant after STARVE_LIMIT
// consecutive denied cycles. Reads return one cycle after grant to the
// port that issued them.
// Optional feature macro: DMEM_ALIGN_CHECK_EN -- misaligned or oddly sized
// accesses are granted but not sent to memory, and the issuing port sees
// err one cycle later instead of rvalid.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8,
    parameter int AGE_W        = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    dmem_req_if.slave   a,
    dmem_req_if.slave   b,
    dmem_mem_if.master  mem
);
    arb_state_t        state_reg;
    arb_state_t        state_next;
    logic [1:0]        gnt_v;
    logic [1:0]        we_v;
    logic [1:0]        fwd_ok_v;
    logic [1:0]        rvalid_v;
    logic [1:0]        err_v;
    logic [DATA_W-1:0] rdata_v [2];
    logic              age_inc;
    logic              age_clr;
    logic              age_reach;

    assign we_v = {b.we, a.we};

`ifdef DMEM_ALIGN_CHECK_EN
    assign fwd_ok_v[0] = access_aligned(a.addr[1:0], a.be);
    assign fwd_ok_v[1] = access_aligned(b.addr[1:0], b.be);
`else
    assign fwd_ok_v = 2'b11;
`endif

    // Grant selection: b wins only when forced or when a is idle. Nothing is
    // granted while reset is held.
    always_comb begin
        gnt_v = 2'b00;
        if (reset_n) begin
            if ((state_reg == ARB_FORCE_B) && b.req) begin
                gnt_v = 2'b10;
            end else if (a.req) begin
                gnt_v = 2'b01;
            end else if (b.req) begin
                gnt_v = 2'b10;
            end
        end
    end

    // FORCE_B lasts one cycle: b is granted there if still requesting, and
    // either way the age is cleared on the way back to NORMAL.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_NORMAL:  if (age_reach) state_next = ARB_FORCE_B;
            ARB_FORCE_B: state_next = ARB_NORMAL;
            default:     state_next = ARB_NORMAL;
        endcase
    end

    assign age_inc = (state_reg == ARB_NORMAL) && b.req && !gnt_v[1];
    assign age_clr = gnt_v[1] || (state_reg == ARB_FORCE_B);

    dmem_age_counter #(
        .AGE_W (AGE_W),
        .LIMIT (STARVE_LIMIT)
    ) u_age (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (age_inc),
        .clr     (age_clr),
        .reach   (age_reach)
    );

    // Arbitration state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ARB_NORMAL;
        end else begin
            state_reg <= state_next;
        end
    end

    // Memory command mux: idle cycles present an all-zero command.
    always_comb begin
        mem.addr     = '0;
        mem.wdata    = '0;
        mem.be       = '0;
        mem.read_en  = 1'b0;
        mem.write_en = 1'b0;
        if (gnt_v[0]) begin
            mem.addr     = a.addr;
            mem.wdata    = a.wdata;
            mem.be       = a.be;
            mem.read_en  = fwd_ok_v[0] && !a.we;
            mem.write_en = fwd_ok_v[0] && a.we;
        end else if (gnt_v[1]) begin
            mem.addr     = b.addr;
            mem.wdata    = b.wdata;
            mem.be       = b.be;
            mem.read_en  = fwd_ok_v[1] && !b.we;
            mem.write_en = fwd_ok_v[1] && b.we;
        end
    end

    // Per-port response path: read ownership pipe, held read data, error pulse.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            logic              rvalid_reg;
            logic [DATA_W-1:0] rdata_hold_reg;

            // Remember which port owns the read in flight and latch returned data.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rvalid_reg     <= 1'b0;
                    rdata_hold_reg <= '0;
                end else begin
                    rvalid_reg <= gnt_v[gi] && fwd_ok_v[gi] && !we_v[gi];
                    if (rvalid_reg) rdata_hold_reg <= mem.rdata;
                end
            end

            assign rvalid_v[gi] = rvalid_reg;
            assign rdata_v[gi]  = rvalid_reg ? mem.rdata : rdata_hold_reg;

`ifdef DMEM_ALIGN_CHECK_EN
            logic err_reg;

            // Rejected accesses report back one cycle after their grant.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    err_reg <= 1'b0;
                end else begin
                    err_reg <= gnt_v[gi] && !fwd_ok_v[gi];
                end
            end

            assign err_v[gi] = err_reg;
`else
            assign err_v[gi] = 1'b0;
`endif
        end
    endgenerate

    assign a.gnt    = gnt_v[0];
    assign a.rvalid = rvalid_v[0];
    assign a.rdata  = rdata_v[0];
    assign a.err    = err_v[0];
    assign b.gnt    = gnt_v[1];
    assign b.rvalid = rvalid_v[1];
    assign b.rdata  = rdata_v[1];
    assign b.err    = err_v[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed reset/priority/pipeline cases followed
// by randomized traffic, checked against a behavioural model of the
// arbitration rules and memory contents via per-port expectation queues.
module tb_dmem_arbiter;
    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 8;
    localparam int AGE_W        = 4;
    localparam int WORDS        = 64;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    typedef struct {
        int                cyc;
        logic [DATA_W-1:0] data;
    } rd_exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   n_vec   = 0;
    int   n_bad   = 0;
    bit   mon_en  = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_req_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) a_if ();
    dmem_req_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b_if ();
    dmem_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

    dmem_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (STARVE_LIMIT),
        .AGE_W        (AGE_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .a       (a_if),
        .b       (b_if),
        .mem     (mem_if)
    );

    // Physical memory: one-cycle registered read, byte-lane writes.
    logic [DATA_W-1:0] phys_mem [WORDS];
    logic [DATA_W-1:0] mem_rdata_reg;
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < WORDS; i++) phys_mem[i] <= '0;
            mem_rdata_reg <= '0;
        end else begin
            if (mem_if.write_en)
                for (int l = 0; l < 4; l++)
                    if (mem_if.be[l]) phys_mem[mem_if.addr[7:2]][8*l +: 8] <= mem_if.wdata[8*l +: 8];
            if (mem_if.read_en) mem_rdata_reg <= phys_mem[mem_if.addr[7:2]];
        end
    end
    assign mem_if.rdata = mem_rdata_reg;

    // Reference model state.
    logic [DATA_W-1:0] ref_mem [WORDS];
    int                b_wait = 0;
    rd_exp_t           rdq [2][$];
    int                errq [2][$];
    logic [DATA_W-1:0] last_rdata [2];

    // Pending request per port (0 = A, 1 = B).
    logic              p_req   [2];
    logic              p_we    [2];
    logic [ADDR_W-1:0] p_addr  [2];
    logic [DATA_W-1:0] p_wdata [2];
    logic [3:0]        p_be    [2];

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // Alignment rule when the check is built in: natural size, address at first lane.
    function automatic bit legal_access(input logic [ADDR_W-1:0] addr, input logic [3:0] be);
        int low;
        bit size_ok;
        low = 4;
        for (int i = 3; i >= 0; i--) if (be[i]) low = i;
        size_ok = (be == 4'b0001) || (be == 4'b0010) || (be == 4'b0100) || (be == 4'b1000) ||
                  (be == 4'b0011) || (be == 4'b1100) || (be == 4'b1111);
        return !ALIGN_CHK || (size_ok && (low == int'(addr[1:0])));
    endfunction

    task automatic drive_ports();
        a_if.req = p_req[0]; a_if.we = p_we[0]; a_if.addr = p_addr[0];
        a_if.wdata = p_wdata[0]; a_if.be = p_be[0];
        b_if.req = p_req[1]; b_if.we = p_we[1]; b_if.addr = p_addr[1];
        b_if.wdata = p_wdata[1]; b_if.be = p_be[1];
    endtask

    task automatic set_req(input int p, input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input logic [3:0] be);
        p_req[p] = 1'b1; p_we[p] = we; p_addr[p] = addr; p_wdata[p] = wdata; p_be[p] = be;
    endtask

    task automatic rand_req(input int p);
        logic [3:0] be;
        int         lo;
        if ($urandom_range(1) == 1) begin
            case ($urandom_range(6))
                0: be = 4'b0001;  1: be = 4'b0010;  2: be = 4'b0100;  3: be = 4'b1000;
                4: be = 4'b0011;  5: be = 4'b1100;  default: be = 4'b1111;
            endcase
            lo = 0;
            for (int i = 3; i >= 0; i--) if (be[i]) lo = i;
        end else begin
            be = 4'($urandom_range(15));
            lo = int'($urandom_range(3));
        end
        set_req(p, 1'($urandom_range(1)), ADDR_W'($urandom_range(WORDS - 1)) * 4 + ADDR_W'(lo),
                DATA_W'($urandom), be);
    endtask

    // One cycle: issue requests, check grant and memory command, update model.
    task automatic step(input int pct_a, input int pct_b);
        bit      ea, eb, ok;
        int      g;
        rd_exp_t e;
        @(negedge clk);
        if (!p_req[0] && ($urandom_range(99) < pct_a)) rand_req(0);
        if (!p_req[1] && ($urandom_range(99) < pct_b)) rand_req(1);
        drive_ports();
        #1;
        eb = p_req[1] && ((b_wait == STARVE_LIMIT) || !p_req[0]);
        ea = p_req[0] && !eb;
        check("a_gnt", a_if.gnt, ea);
        check("b_gnt", b_if.gnt, eb);
        g = ea ? 0 : (eb ? 1 : -1);
        if (p_req[1] && !eb) b_wait++;
        else                 b_wait = 0;
        if (g >= 0) begin
            ok = legal_access(p_addr[g], p_be[g]);
            check("mem_addr", mem_if.addr, p_addr[g]);
            check("mem_wdata", mem_if.wdata, p_wdata[g]);
            check("mem_be", mem_if.be, p_be[g]);
            check("mem_read_en", mem_if.read_en, ok && !p_we[g]);
            check("mem_write_en", mem_if.write_en, ok && p_we[g]);
            if (!ok) begin
                errq[g].push_back(cyc + 1);
            end else if (!p_we[g]) begin
                e.cyc  = cyc + 1;
                e.data = ref_mem[p_addr[g][7:2]];
                rdq[g].push_back(e);
            end else begin
                for (int l = 0; l < 4; l++)
                    if (p_be[g][l]) ref_mem[p_addr[g][7:2]][8*l +: 8] = p_wdata[g][8*l +: 8];
            end
            p_req[g] = 1'b0;
        end else begin
            check("idle_read_en", mem_if.read_en, 0);
            check("idle_write_en", mem_if.write_en, 0);
            check("idle_addr", mem_if.addr, 0);
            check("idle_wdata", mem_if.wdata, 0);
            check("idle_be", mem_if.be, 0);
        end
    endtask

    // Response monitor for one port: rvalid/err timing, data, and data hold.
    task automatic mon_port(input int p);
        logic              rv, er;
        logic [DATA_W-1:0] rd;
        bit                exp_rv, exp_er;
        rd_exp_t           e;
        rv = (p == 0) ? a_if.rvalid : b_if.rvalid;
        er = (p == 0) ? a_if.err    : b_if.err;
        rd = (p == 0) ? a_if.rdata  : b_if.rdata;
        exp_rv = (rdq[p].size() > 0) && (rdq[p][0].cyc == cyc);
        check((p == 0) ? "a_rvalid" : "b_rvalid", rv, exp_rv);
        if (exp_rv) begin
            e = rdq[p].pop_front();
            check((p == 0) ? "a_rdata" : "b_rdata", rd, e.data);
            last_rdata[p] = e.data;
        end else begin
            check((p == 0) ? "a_rdata_hold" : "b_rdata_hold", rd, last_rdata[p]);
        end
        exp_er = (errq[p].size() > 0) && (errq[p][0] == cyc);
        check((p == 0) ? "a_err" : "b_err", er, exp_er);
        if (exp_er) void'(errq[p].pop_front());
    endtask

    initial begin
        last_rdata[0] = '0;
        last_rdata[1] = '0;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) for (int p = 0; p < 2; p++) mon_port(p);
        end
    end

    initial begin
        for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
        for (int p = 0; p < 2; p++) begin
            p_req[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0; p_be[p] = '0;
        end
        // Requests held during reset must be ignored and all outputs stay 0.
        set_req(0, 1'b0, 32'h10, '0, 4'hF);
        set_req(1, 1'b1, 32'h14, 32'h1234_5678, 4'hF);
        drive_ports();
        repeat (2) @(negedge clk);
        #1;
        check("rst_a_gnt", a_if.gnt, 0);
        check("rst_b_gnt", b_if.gnt, 0);
        check("rst_read_en", mem_if.read_en, 0);
        check("rst_write_en", mem_if.write_en, 0);
        check("rst_a_rvalid", a_if.rvalid, 0);
        check("rst_b_rvalid", b_if.rvalid, 0);
        check("rst_a_err", a_if.err, 0);
        check("rst_b_err", b_if.err, 0);
        check("rst_a_rdata", a_if.rdata, 0);
        check("rst_b_rdata", b_if.rdata, 0);
        p_req[0] = 1'b0; p_req[1] = 1'b0;
        drive_ports();
        reset_n = 1'b1;

        // Reset arriving after an A read grant drops that read.
        @(negedge clk);
        set_req(0, 1'b0, 32'h10, '0, 4'hF);
        drive_ports();
        #1;
        check("mid_a_gnt", a_if.gnt, 1);
        #2 reset_n = 1'b0;
        @(negedge clk);
        p_req[0] = 1'b0;
        drive_ports();
        #1;
        check("mid_a_rvalid", a_if.rvalid, 0);
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            check("post_a_rvalid", a_if.rvalid, 0);
            check("post_a_rdata", a_if.rdata, 0);
        end
        b_wait = 0;
        mon_en = 1'b1;

        // Write then read back on A.
        set_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF); step(0, 0);
        set_req(0, 1'b0, 32'h10, '0, 4'hF);            step(0, 0);
        step(0, 0);
        // Same-cycle conflict: A first, B the cycle after.
        set_req(0, 1'b0, 32'h10, '0, 4'hF);
        set_req(1, 1'b0, 32'h10, '0, 4'hF);            step(0, 0);
        step(0, 0);
        // Back-to-back reads alternating owners.
        set_req(0, 1'b0, 32'h0, '0, 4'hF);             step(0, 0);
        set_req(1, 1'b0, 32'h4, '0, 4'hF);             step(0, 0);
        set_req(0, 1'b0, 32'h8, '0, 4'hF);             step(0, 0);
        // Halfword at a misaligned address, then a correctly placed byte.
        set_req(0, 1'b0, 32'h3, '0, 4'b0011);          step(0, 0);
        set_req(0, 1'b0, 32'h2, '0, 4'b0100);          step(0, 0);
        // Continuous traffic on both ports exercises the starvation guard.
        repeat (20)  step(100, 100);
        repeat (300) step(50, 50);
        repeat (40)  step(100, 100);
        repeat (200) step(30, 80);
        repeat (4)   step(0, 0);
        @(negedge clk);
        #2;
        check("a_reads_outstanding", rdq[0].size(), 0);
        check("b_reads_outstanding", rdq[1].size(), 0);
        check("a_errs_outstanding", errq[0].size(), 0);
        check("b_errs_outstanding", errq[1].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
